// File: rtl/param_shift_register_pkg.sv
// Shared types and helpers for the parameterised shift register:
// the shift-mode encoding and a ceiling-log2 for sizing derived fields.
package param_shift_register_pkg;

  typedef enum logic [1:0] {
    SHIFT_FWD = 2'd0,
    SHIFT_REV = 2'd1,
    ROTATE    = 2'd2,
    RSVD      = 2'd3
  } mode_e;

  // Ceiling log2 with clog2(1) = 0, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/param_shift_register_if.sv
// Control, data and status bundle of the shift register; the master side
// drives shift/mode/data/clear/tap select, the slave side returns status.
interface param_shift_register_if
  import param_shift_register_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);

  localparam int TAPW = clog2(DEPTH);
  localparam int CNTW = clog2(DEPTH + 1);

  logic              io_shift;
  mode_e             io_mode;
  logic [WIDTH-1:0]  io_in;
  logic              io_in_valid;
  logic              io_clear;
  logic [TAPW-1:0]   io_tap_sel;
  logic [WIDTH-1:0]  io_out;
  logic              io_out_valid;
  logic [WIDTH-1:0]  io_tap_out;
  logic [CNTW-1:0]   io_count;
  logic              io_full;

  modport master (
    output io_shift, io_mode, io_in, io_in_valid, io_clear, io_tap_sel,
    input  io_out, io_out_valid, io_tap_out, io_count, io_full
  );

  modport slave (
    input  io_shift, io_mode, io_in, io_in_valid, io_clear, io_tap_sel,
    output io_out, io_out_valid, io_tap_out, io_count, io_full
  );

endinterface

// File: rtl/param_shift_register_shift_stage.sv
// One storage stage: a data word plus its valid flag, with async active-low
// reset, synchronous clear (dominant) and a load enable.
module shift_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_out <= '0;
      v_out <= 1'b0;
    end else if (clear) begin
      d_out <= '0;
      v_out <= 1'b0;
    end else if (load) begin
      d_out <= d_in;
      v_out <= v_in;
    end
  end

endmodule

// File: rtl/param_shift_register.sv
// Bidirectional/rotating shift register of DEPTH stages with a running
// count of valid entries, a selectable combinational tap and a full flag.
module param_shift_register
  import param_shift_register_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  param_shift_register_if.slave bus
);

  localparam int TAPW = clog2(DEPTH);
  localparam int CNTW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] stage_d [DEPTH];
  logic             stage_v [DEPTH];
  logic             load;
  logic             rot;
  logic             rev;
  logic [CNTW-1:0]  count_q;
  logic [CNTW-1:0]  count_nxt;

  // Reserved mode is a full no-op, so it never enables the stages.
  assign load = bus.io_shift && (bus.io_mode != RSVD);
  assign rot  = (bus.io_mode == ROTATE);
  assign rev  = (bus.io_mode == SHIFT_REV);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] fwd_d;
    logic             fwd_v;
    logic [WIDTH-1:0] rev_d;
    logic             rev_v;

    if (i == 0) begin : g_head
      assign fwd_d = rot ? stage_d[DEPTH-1] : bus.io_in;
      assign fwd_v = rot ? stage_v[DEPTH-1] : bus.io_in_valid;
    end else begin : g_body
      assign fwd_d = stage_d[i-1];
      assign fwd_v = stage_v[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign rev_d = bus.io_in;
      assign rev_v = bus.io_in_valid;
    end else begin : g_inner
      assign rev_d = stage_d[i+1];
      assign rev_v = stage_v[i+1];
    end

    shift_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .clear (bus.io_clear),
      .d_in  (rev ? rev_d : fwd_d),
      .v_in  (rev ? rev_v : fwd_v),
      .d_out (stage_d[i]),
      .v_out (stage_v[i])
    );
  end

  // Count tracks entries crossing the ends; rotation moves nothing in or out.
  always_comb begin
    count_nxt = count_q;
    if (bus.io_clear) begin
      count_nxt = '0;
    end else if (bus.io_shift) begin
      case (bus.io_mode)
        SHIFT_FWD: count_nxt = count_q + CNTW'(bus.io_in_valid) - CNTW'(stage_v[DEPTH-1]);
        SHIFT_REV: count_nxt = count_q + CNTW'(bus.io_in_valid) - CNTW'(stage_v[0]);
        default:   count_nxt = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_nxt;
    end
  end

  // Selects past the last stage (non-power-of-two DEPTH) read as zero.
  always_comb begin
    bus.io_tap_out = '0;
    if (int'(bus.io_tap_sel) < DEPTH) begin
      bus.io_tap_out = stage_d[bus.io_tap_sel];
    end
  end

  assign bus.io_out       = stage_d[DEPTH-1];
  assign bus.io_out_valid = stage_v[DEPTH-1];
  assign bus.io_count     = count_q;
  assign bus.io_full      = (count_q == CNTW'(DEPTH));

endmodule

// File: tb/tb_param_shift_register.sv
// Directed and randomized bench for param_shift_register (WIDTH=4, DEPTH=4)
// against an array-based model of the stage contents.
module tb_param_shift_register;
  import param_shift_register_pkg::*;

  localparam int W = 4;
  localparam int D = 4;

  logic clock;
  logic reset;

  param_shift_register_if #(.WIDTH(W), .DEPTH(D)) bus ();

  param_shift_register #(.WIDTH(W), .DEPTH(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp;
  int n_bad;

  logic [W-1:0] m_d [D];
  logic         m_v [D];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int popcount();
    int n;
    n = 0;
    for (int i = 0; i < D; i++) n += int'(m_v[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_d[i] = '0;
      m_v[i] = 1'b0;
    end
  endtask

  // Applies the effect of the next active edge given the driven inputs.
  task automatic model_edge();
    logic [W-1:0] od [D];
    logic         ov [D];
    for (int i = 0; i < D; i++) begin
      od[i] = m_d[i];
      ov[i] = m_v[i];
    end
    if (bus.io_clear) begin
      model_clear();
    end else if (bus.io_shift) begin
      case (bus.io_mode)
        SHIFT_FWD: begin
          for (int i = 1; i < D; i++) begin m_d[i] = od[i-1]; m_v[i] = ov[i-1]; end
          m_d[0] = bus.io_in;
          m_v[0] = bus.io_in_valid;
        end
        SHIFT_REV: begin
          for (int i = 0; i < D - 1; i++) begin m_d[i] = od[i+1]; m_v[i] = ov[i+1]; end
          m_d[D-1] = bus.io_in;
          m_v[D-1] = bus.io_in_valid;
        end
        ROTATE: begin
          for (int i = 0; i < D; i++) begin m_d[(i+1)%D] = od[i]; m_v[(i+1)%D] = ov[i]; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    int exp_tap;
    exp_tap = (int'(bus.io_tap_sel) < D) ? int'(m_d[bus.io_tap_sel]) : 0;
    check({tag, ".out"},       32'(bus.io_out),       32'(m_d[D-1]));
    check({tag, ".out_valid"}, 32'(bus.io_out_valid), 32'(m_v[D-1]));
    check({tag, ".count"},     32'(bus.io_count),     32'(popcount()));
    check({tag, ".full"},      32'(bus.io_full),      32'(popcount() == D));
    check({tag, ".tap"},       32'(bus.io_tap_out),   32'(exp_tap));
  endtask

  task automatic step(input string tag, input logic sh, input mode_e md,
                      input logic [W-1:0] din, input logic dv, input logic clr);
    bus.io_shift    = sh;
    bus.io_mode     = md;
    bus.io_in       = din;
    bus.io_in_valid = dv;
    bus.io_clear    = clr;
    model_edge();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".out"},       32'(bus.io_out),       32'd0);
    check({tag, ".out_valid"}, 32'(bus.io_out_valid), 32'd0);
    check({tag, ".count"},     32'(bus.io_count),     32'd0);
    check({tag, ".full"},      32'(bus.io_full),      32'd0);
    check({tag, ".tap"},       32'(bus.io_tap_out),   32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_clear();
    reset           = 1'b0;
    bus.io_shift    = 1'b0;
    bus.io_mode     = SHIFT_FWD;
    bus.io_in       = '0;
    bus.io_in_valid = 1'b0;
    bus.io_clear    = 1'b0;
    bus.io_tap_sel  = '0;
    #1;
    check_zero_outputs("reset");
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Forward load 1,2,3,4: first entry appears at the output after 4 shifts.
    for (int k = 1; k <= 4; k++) step("fwd_load", 1'b1, SHIFT_FWD, W'(k), 1'b1, 1'b0);
    check("fwd_load.out1",  32'(bus.io_out),       32'd1);
    check("fwd_load.ov1",   32'(bus.io_out_valid), 32'd1);
    check("fwd_load.cnt4",  32'(bus.io_count),     32'd4);
    check("fwd_load.full1", 32'(bus.io_full),      32'd1);

    // Idle cycles must not advance anything.
    step("idle", 1'b0, SHIFT_FWD, 4'hF, 1'b1, 1'b0);
    step("rsvd", 1'b1, RSVD, 4'hF, 1'b1, 1'b0);

    step("full_shift", 1'b1, SHIFT_FWD, 4'd5, 1'b1, 1'b0);
    check("full_shift.out2", 32'(bus.io_out),   32'd2);
    check("full_shift.cnt4", 32'(bus.io_count), 32'd4);

    // Reload 1,2,3,4 then rotate a full turn.
    step("reload_clr", 1'b0, SHIFT_FWD, 4'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) step("reload", 1'b1, SHIFT_FWD, W'(k), 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      bus.io_tap_sel = 2'(k);
      step("rotate", 1'b1, ROTATE, 4'hC, 1'b0, 1'b0);
      check("rotate.cnt", 32'(bus.io_count), 32'd4);
    end
    check("rotate.out1", 32'(bus.io_out), 32'd1);

    // Clear beats a simultaneous shift.
    step("clear", 1'b1, SHIFT_FWD, 4'h7, 1'b1, 1'b1);
    check("clear.cnt0", 32'(bus.io_count),     32'd0);
    check("clear.ov0",  32'(bus.io_out_valid), 32'd0);
    for (int s = 0; s < D; s++) begin
      bus.io_tap_sel = 2'(s);
      #1;
      check("clear.tap0", 32'(bus.io_tap_out), 32'd0);
    end

    // Reverse entry enters at the tail.
    step("rev", 1'b1, SHIFT_REV, 4'hA, 1'b1, 1'b0);
    step("rev", 1'b1, SHIFT_REV, 4'hA, 1'b1, 1'b0);
    bus.io_tap_sel = 2'd2;
    #1;
    check("rev.tapA", 32'(bus.io_tap_out), 32'hA);
    check("rev.cnt2", 32'(bus.io_count),   32'd2);

    // Mid-sequence reset takes effect between edges.
    for (int k = 0; k < 3; k++) step("pre_rst", 1'b1, SHIFT_FWD, W'(k + 9), 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_zero_outputs("async_rst");
    @(posedge clock);
    #1;
    check_zero_outputs("rst_hold");
    reset = 1'b1;
    step("post_rst", 1'b1, SHIFT_FWD, 4'h6, 1'b1, 1'b0);

    // Randomized traffic across all modes.
    for (int n = 0; n < 400; n++) begin
      bus.io_tap_sel = 2'($urandom_range(0, D - 1));
      step("rand", 1'($urandom_range(0, 3) != 0), mode_e'($urandom_range(0, 3)),
           W'($urandom), 1'($urandom), 1'($urandom_range(0, 31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
